// File: rtl/load_store_unit.sv
// RV32I load/store requester for a single-port word memory.
// Sub-word stores are done as read-modify-write; loads are lane-extracted and extended.
module load_store_unit #(
  parameter int ADDR_WIDTH     = 32,
  parameter int MEM_ADDR_WIDTH = 30
) (
  input  logic                      I_clk,
  input  logic                      I_rst,
  input  logic                      I_req,
  input  logic                      I_we,
  input  logic [2:0]                I_funct3,
  input  logic [ADDR_WIDTH-1:0]     I_addr,
  input  logic [31:0]               I_wdata,
  output logic                      O_busy,
  output logic                      O_done,
  output logic                      O_fault,
  output logic [31:0]               O_rdata,
  output logic                      O_mem_memrw,
  output logic [MEM_ADDR_WIDTH-1:0] O_mem_address,
  output logic [31:0]               O_mem_data,
  input  logic [31:0]               I_mem_data
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WRITE,
    DONE,
    FAULT
  } state_t;

  state_t state;
  state_t state_next;

  logic        accept;
  logic        illegal;
  logic        is_sw;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [1:0]  lane_q;
  logic [15:0] wdata_q;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_val;
  logic [31:0] merged;

  assign accept = (state == IDLE) && I_req;
  assign is_sw  = I_we && (I_funct3 == 3'b010);

  always_comb begin
    illegal = 1'b0;
    unique case (I_funct3)
      3'b000:  illegal = 1'b0;
      3'b001:  illegal = I_addr[0];
      3'b010:  illegal = |I_addr[1:0];
      3'b100:  illegal = I_we;
      3'b101:  illegal = I_we || I_addr[0];
      default: illegal = 1'b1;
    endcase
  end

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (illegal) state_next = FAULT;
          else if (is_sw) state_next = WRITE;
          else state_next = READ;
        end
      end
      READ:    state_next = we_q ? WRITE : DONE;
      WRITE:   state_next = DONE;
      DONE:    state_next = IDLE;
      FAULT:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Memory write strobe is decoded from state so reset kills it at once.
  always_comb begin
    O_busy      = (state != IDLE);
    O_done      = (state == DONE) || (state == FAULT);
    O_fault     = (state == FAULT);
    O_mem_memrw = (state == WRITE);
  end

  always_comb begin
    byte_sel = I_mem_data[{lane_q, 3'b000} +: 8];
    half_sel = I_mem_data[{lane_q[1], 4'b0000} +: 16];
    unique case (funct3_q[1:0])
      2'b00:   load_val = {{24{byte_sel[7] & ~funct3_q[2]}}, byte_sel};
      2'b01:   load_val = {{16{half_sel[15] & ~funct3_q[2]}}, half_sel};
      default: load_val = I_mem_data;
    endcase
  end

  always_comb begin
    merged = I_mem_data;
    if (funct3_q[0]) begin
      merged[{lane_q[1], 4'b0000} +: 16] = wdata_q;
    end else begin
      merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
    end
  end

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      we_q          <= 1'b0;
      funct3_q      <= 3'b000;
      lane_q        <= 2'b00;
      wdata_q       <= 16'h0000;
      O_rdata       <= 32'h0;
      O_mem_address <= '0;
      O_mem_data    <= 32'h0;
    end else if (accept) begin
      we_q     <= I_we;
      funct3_q <= I_funct3;
      lane_q   <= I_addr[1:0];
      wdata_q  <= I_wdata[15:0];
      O_rdata  <= 32'h0;
      if (!illegal) begin
        O_mem_address <= I_addr[ADDR_WIDTH-1:2];
      end
      if (!illegal && is_sw) begin
        O_mem_data <= I_wdata;
      end
    end else if (state == READ) begin
      if (we_q) begin
        O_mem_data <= merged;
      end else begin
        O_rdata <= load_val;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a byte-array reference memory.
// A word memory model answers the DUT's memory port combinationally.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        busy;
  logic        done;
  logic        fault;
  logic [31:0] rdata;
  logic        mem_memrw;
  logic [29:0] mem_address;
  logic [31:0] mem_data;
  logic [31:0] mem_rdata;

  load_store_unit #(
    .ADDR_WIDTH(32),
    .MEM_ADDR_WIDTH(30)
  ) dut (
    .I_clk(clk),
    .I_rst(rst),
    .I_req(req),
    .I_we(we),
    .I_funct3(funct3),
    .I_addr(addr),
    .I_wdata(wdata),
    .O_busy(busy),
    .O_done(done),
    .O_fault(fault),
    .O_rdata(rdata),
    .O_mem_memrw(mem_memrw),
    .O_mem_address(mem_address),
    .O_mem_data(mem_data),
    .I_mem_data(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] mem [0:63];
  assign mem_rdata = (mem_address[29:6] == 24'd0) ? mem[mem_address[5:0]] : 32'h0;
  always @(posedge clk) begin
    if (mem_memrw && mem_address[29:6] == 24'd0) mem[mem_address[5:0]] <= mem_data;
  end

  typedef struct {
    logic        fault;
    logic [31:0] rdata;
    bit          chk_rdata;
    bit          store;
    int          widx;
    int          cyc;
    int          writes;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  logic [7:0]  rbytes [0:255];
  int          tests = 0;
  int          fails = 0;
  int          pushed = 0;
  int          done_seen = 0;
  int          wr_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_word(input int w);
    return {rbytes[4*w+3], rbytes[4*w+2], rbytes[4*w+1], rbytes[4*w]};
  endfunction

  // Reference: byte-addressed memory, width in bytes, extension by arithmetic.
  function automatic exp_t model(input logic w, input logic [2:0] f,
                                 input logic [31:0] a, input logic [31:0] d,
                                 input int acc);
    exp_t r;
    int nb;
    int base;
    int lat;
    logic [31:0] v;
    r.fault = (f == 3'b011) || (f[2:1] == 2'b11) || (w && f[2]) ||
              (f[1:0] == 2'b01 && a[0]) || (f == 3'b010 && a[1:0] != 2'b00);
    nb = 1 << f[1:0];
    base = int'(a[7:0]);
    r.widx = int'(a[7:2]);
    r.rdata = 32'h0;
    r.chk_rdata = 1'b0;
    r.store = 1'b0;
    r.writes = 0;
    if (r.fault) begin
      r.chk_rdata = 1'b1;
      lat = 1;
    end else if (w) begin
      for (int i = 0; i < nb; i++) rbytes[base+i] = d[8*i +: 8];
      r.store = 1'b1;
      r.writes = 1;
      lat = (nb == 4) ? 2 : 3;
    end else begin
      v = 32'h0;
      for (int i = 0; i < nb; i++) v = v | (32'(rbytes[base+i]) << (8*i));
      if (!f[2] && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
      r.rdata = v;
      r.chk_rdata = 1'b1;
      lat = 2;
    end
    r.cyc = acc + lat - 1;
    return r;
  endfunction

  function automatic void push(input exp_t x);
    exp_q.push_back(x);
    pushed++;
  endfunction

  task automatic issue(input logic w, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] d, input bit hold);
    int n = 0;
    @(negedge clk);
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      check("idle_timeout", {31'h0, busy}, 32'h0);
      return;
    end
    we = w;
    funct3 = f;
    addr = a;
    wdata = d;
    req = 1'b1;
    @(posedge clk);
    #1;
    push(model(w, f, a, d, cyc));
    if (!hold) req = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      wr_cnt = 0;
    end else begin
      if (mem_memrw) wr_cnt++;
      if (done) begin
        done_seen++;
        if (exp_q.size() == 0) begin
          check("spurious_done", {31'h0, done}, 32'h0);
        end else begin
          e = exp_q.pop_front();
          check("fault", {31'h0, fault}, {31'h0, e.fault});
          check("latency", cyc, e.cyc);
          check("write_cycles", wr_cnt, e.writes);
          if (e.chk_rdata) check("rdata", rdata, e.rdata);
          if (e.store) check("mem_word", mem[e.widx], ref_word(e.widx));
        end
        wr_cnt = 0;
      end
    end
  end

  logic [31:0] snap;
  int          a0;
  int          n;

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_fault", {31'h0, fault}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_memrw", {31'h0, mem_memrw}, 32'h0);
    check("rst_mem_address", {2'b00, mem_address}, 32'h0);
    check("rst_mem_data", mem_data, 32'h0);

    // Reset asserted while a SW sits in WRITE.
    rst = 1'b0;
    @(negedge clk);
    snap = mem[4];
    we = 1'b1;
    funct3 = 3'b010;
    addr = 32'h10;
    wdata = 32'h1234_5678;
    req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    #1 check("pre_rst_memrw", {31'h0, mem_memrw}, 32'h1);
    rst = 1'b1;
    #1;
    check("midrst_memrw", {31'h0, mem_memrw}, 32'h0);
    check("midrst_busy", {31'h0, busy}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    check("midrst_mem_word", mem[4], snap);
    rst = 1'b0;

    for (int w = 0; w < 64; w++) issue(1'b1, 3'b010, 32'(w * 4), $urandom, 1'b0);

    issue(1'b1, 3'b010, 32'h8, 32'hDEAD_BEEF, 1'b0);
    issue(1'b0, 3'b010, 32'h8, 32'h0, 1'b0);
    issue(1'b1, 3'b000, 32'h9, 32'h0000_0055, 1'b0);
    issue(1'b0, 3'b000, 32'h8, 32'h0, 1'b0);
    issue(1'b0, 3'b100, 32'h8, 32'h0, 1'b0);
    issue(1'b0, 3'b001, 32'hA, 32'h0, 1'b0);
    issue(1'b0, 3'b101, 32'hA, 32'h0, 1'b0);
    issue(1'b0, 3'b010, 32'h6, 32'h0, 1'b0);
    issue(1'b1, 3'b001, 32'h3, 32'hFFFF_FFFF, 1'b0);
    issue(1'b0, 3'b011, 32'h8, 32'h0, 1'b0);

    // Request held high across a busy SB; the held LW lands on the first IDLE cycle.
    issue(1'b1, 3'b000, 32'h21, 32'h0000_00A5, 1'b1);
    a0 = cyc;
    we = 1'b0;
    funct3 = 3'b010;
    addr = 32'h20;
    push(model(1'b0, 3'b010, 32'h20, 32'h0, a0 + 4));
    n = 0;
    while (cyc < a0 + 4 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("held_req_accept", {31'h0, busy}, 32'h1);
    req = 1'b0;

    repeat (300) begin
      issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            32'($urandom_range(0, 255)), $urandom, 1'b0);
    end

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'h0);
    check("done_count", done_seen, pushed);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
